// File: rtl/tank_game_pkg.sv
// tank_game_pkg: shared shell FSM states and default playfield/ballistics constants.
package tank_game_pkg;
  typedef enum logic [1:0] {IDLE, FLIGHT, EXPLODE} shell_state_e;
  localparam int X_MAX_DEF          = 639;
  localparam int Y_MAX_DEF          = 479;
  localparam int GRAVITY_DIV_DEF    = 4;
  localparam int EXPLODE_FRAMES_DEF = 16;
  localparam int VY_LIM_DEF         = 15;
endpackage

// File: rtl/shell_hit_test.sv
// shell_hit_test: combinational box overlap of a signed shell position against an enemy tank.
module shell_hit_test (
  input  logic signed [10:0] shell_x,
  input  logic signed [10:0] shell_y,
  input  logic        [9:0]  enemy_x,
  input  logic        [9:0]  enemy_y,
  input  logic        [9:0]  enemy_s,
  output logic               hit
);
  logic [11:0] dx, dy, ax, ay, lim;
  always_comb begin
    dx  = {shell_x[10], shell_x} - {2'b0, enemy_x};
    dy  = {shell_y[10], shell_y} - {2'b0, enemy_y};
    ax  = dx[11] ? 12'(-dx) : dx;
    ay  = dy[11] ? 12'(-dy) : dy;
    lim = {2'b0, enemy_s} + 12'd2;
    hit = (ax <= lim) && (ay <= lim);
  end
endmodule

// File: rtl/projectile_ctrl.sv
// projectile_ctrl: one-shell-at-a-time ballistic projectile with gravity, bounds and hit detection.
module projectile_ctrl
  import tank_game_pkg::*;
#(
  parameter int X_MAX          = X_MAX_DEF,
  parameter int Y_MAX          = Y_MAX_DEF,
  parameter int GRAVITY_DIV    = GRAVITY_DIV_DEF,
  parameter int EXPLODE_FRAMES = EXPLODE_FRAMES_DEF,
  parameter int VY_LIM         = VY_LIM_DEF
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       shoot,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [9:0] TankS,
  input  logic [1:0] Direction,
  input  logic [9:0] y_component,
  input  logic [1:0] weapon,
  input  logic [9:0] EnemyX,
  input  logic [9:0] EnemyY,
  input  logic [9:0] EnemyS,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic       ShellActive,
  output logic       Exploding,
  output logic       hit
);
  localparam logic signed [10:0] XLIM  = 11'(X_MAX);
  localparam logic signed [10:0] YLIM  = 11'(Y_MAX);
  localparam logic signed [10:0] VLIM  = 11'(VY_LIM);
  localparam logic        [7:0]  GLAST = 8'(GRAVITY_DIV - 1);
  localparam logic        [7:0]  ELAST = 8'(EXPLODE_FRAMES - 1);
  shell_state_e       state_q, state_d;
  logic signed [10:0] x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
  logic signed [10:0] nx, ny, tank_y, vx_mag, vy_neg, vy_launch;
  logic        [7:0]  grav_q, grav_d, exp_q, exp_d;
  logic               hit_q, hit_d, overlap, out_of_bounds;
  shell_hit_test u_hit (
    .shell_x(x_q),
    .shell_y(y_q),
    .enemy_x(EnemyX),
    .enemy_y(EnemyY),
    .enemy_s(EnemyS),
    .hit(overlap)
  );
  always_comb begin
    tank_y        = $signed({1'b0, TankY}) - $signed({1'b0, TankS}) - 11'sd1;
    vx_mag        = $signed({9'b0, weapon}) + 11'sd1;
    vy_neg        = -$signed({y_component[9], y_component});
    vy_launch     = vy_neg > VLIM ? VLIM : vy_neg < -VLIM ? -VLIM : vy_neg;
    nx            = x_q + vx_q;
    ny            = y_q + vy_q;
    out_of_bounds = nx < 0 || nx > XLIM || ny >= YLIM;
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    vx_d          = vx_q;
    vy_d          = vy_q;
    grav_d        = grav_q;
    exp_d         = exp_q;
    hit_d         = 1'b0;
    case (state_q)
      IDLE: if (shoot) begin
        state_d = FLIGHT;
        vx_d    = Direction == 2'd0 ? -vx_mag : Direction == 2'd1 ? vx_mag : '0;
        vy_d    = vy_launch;
        grav_d  = '0;
      end
      FLIGHT: if (overlap) begin
        state_d = EXPLODE;
        hit_d   = 1'b1;
        exp_d   = '0;
      end else if (out_of_bounds) begin
        state_d = IDLE;
      end else begin
        x_d    = nx;
        y_d    = ny;
        grav_d = grav_q == GLAST ? '0 : grav_q + 8'd1;
        vy_d   = grav_q == GLAST ? vy_q + 11'sd1 : vy_q;
      end
      EXPLODE: begin
        exp_d   = exp_q + 8'd1;
        state_d = exp_q == ELAST ? IDLE : EXPLODE;
      end
      default: state_d = IDLE;
    endcase
    // Idle shells sit on the tank muzzle, so launch and every idle frame reload it.
    if (state_q == IDLE || state_d == IDLE) begin
      x_d = $signed({1'b0, TankX});
      y_d = tank_y;
    end
  end
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      grav_q  <= '0;
      exp_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      grav_q  <= grav_d;
      exp_q   <= exp_d;
      hit_q   <= hit_d;
    end
  assign ShellX      = x_q[9:0];
  assign ShellY      = y_q[10] ? '0 : y_q[9:0];
  assign ShellActive = state_q != IDLE;
  assign Exploding   = state_q == EXPLODE;
  assign hit         = hit_q;
endmodule

// File: tb/tb_projectile_ctrl.sv
// tb_projectile_ctrl: directed and randomized shots checked against a per-frame ballistic model.
module tb_projectile_ctrl;
  localparam int XM = 639, YM = 479, GD = 4, EF = 16, VL = 15;
  logic       frame_clk = 0, Reset = 1, shoot = 0;
  logic [9:0] TankX = 0, TankY = 0, TankS = 0, y_component = 0;
  logic [9:0] EnemyX = 0, EnemyY = 0, EnemyS = 0;
  logic [1:0] Direction = 0, weapon = 0;
  logic [9:0] ShellX, ShellY;
  logic       ShellActive, Exploding, hit;
  int n_checks = 0, n_fail = 0;
  int m_mode = 0, m_x = 0, m_y = 0, m_vx = 0, m_vy0 = 0, m_k = 0, m_left = 0, m_hit = 0;
  int hit_cnt = 0, expl_cnt = 0, act_cnt = 0;

  projectile_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .shoot(shoot),
    .TankX(TankX), .TankY(TankY), .TankS(TankS),
    .Direction(Direction), .y_component(y_component), .weapon(weapon),
    .EnemyX(EnemyX), .EnemyY(EnemyY), .EnemyS(EnemyS),
    .ShellX(ShellX), .ShellY(ShellY), .ShellActive(ShellActive),
    .Exploding(Exploding), .hit(hit)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic int clampv(input int v);
    return v > VL ? VL : v < -VL ? -VL : v;
  endfunction

  // Gravity: the k-th position update (0-based) moves by vy0 + k/GD.
  task automatic model_step();
    int nx, ny, yc;
    m_hit = 0;
    if (m_mode == 1) begin
      if (iabs(m_x - int'(EnemyX)) <= int'(EnemyS) + 2 && iabs(m_y - int'(EnemyY)) <= int'(EnemyS) + 2) begin
        m_mode = 2; m_hit = 1; m_left = EF;
      end else begin
        nx = m_x + m_vx;
        ny = m_y + m_vy0 + m_k / GD;
        if (nx < 0 || nx > XM || ny >= YM) m_mode = 0;
        else begin m_x = nx; m_y = ny; m_k++; end
      end
    end else if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end else if (shoot) begin
      yc = $signed(y_component);
      m_mode = 1;
      m_vx = Direction == 0 ? -(int'(weapon) + 1) : Direction == 1 ? int'(weapon) + 1 : 0;
      m_vy0 = clampv(-yc);
      m_k = 0;
      m_x = TankX; m_y = int'(TankY) - int'(TankS) - 1;
    end
    if (m_mode == 0) begin m_x = TankX; m_y = int'(TankY) - int'(TankS) - 1; end
  endtask

  task automatic compare(input string t);
    check({t, "_x"}, ShellX, m_x & 1023);
    check({t, "_y"}, ShellY, m_y < 0 ? 0 : m_y & 1023);
    check({t, "_active"}, ShellActive, m_mode != 0);
    check({t, "_expl"}, Exploding, m_mode == 2);
    check({t, "_hit"}, hit, m_hit);
  endtask

  task automatic cycle();
    @(posedge frame_clk);
    model_step();
    #1;
    compare("cyc");
    hit_cnt += hit;
    expl_cnt += Exploding;
    act_cnt += ShellActive;
    @(negedge frame_clk);
  endtask

  task automatic do_reset();
    Reset = 1;
    #1;
    m_mode = 0; m_x = 0; m_y = 0; m_hit = 0;
    compare("rst");
    @(negedge frame_clk);
    Reset = 0;
  endtask

  task automatic finish_shot();
    int n = 0;
    while (ShellActive && n < 2000) begin cycle(); n++; end
    shoot = 0;
    check("shot_timeout", n < 2000, 1);
  endtask

  task automatic shot(input bit hold);
    hit_cnt = 0; expl_cnt = 0; act_cnt = 0;
    shoot = 1;
    cycle();
    if (!hold) shoot = 0;
    finish_shot();
  endtask

  task automatic set_tank(input int tx, input int ty, input int ts, input int dir, input int wp, input int yc);
    TankX = 10'(tx); TankY = 10'(ty); TankS = 10'(ts);
    Direction = 2'(dir); weapon = 2'(wp); y_component = 10'(yc);
  endtask

  task automatic set_enemy(input int ex, input int ey, input int es);
    EnemyX = 10'(ex); EnemyY = 10'(ey); EnemyS = 10'(es);
  endtask

  initial begin
    #1;
    compare("por");
    @(negedge frame_clk);
    do_reset();
    cycle();
    // Leftward shell, flat aim: x steps by 2, y holds for four updates.
    set_tank(550, 200, 4, 0, 1, 0);
    set_enemy(100, 50, 4);
    shoot = 1;
    cycle();
    shoot = 0;
    check("r41_x0", ShellX, 550);
    check("r41_y0", ShellY, 195);
    cycle(); cycle();
    check("r41_x2", ShellX, 546);
    cycle(); cycle();
    check("r41_y4", ShellY, 195);
    cycle();
    check("r41_y5", ShellY, 196);
    finish_shot();
    check("r41_nohit", hit_cnt, 0);
    // Same shot into an enemy.
    set_enemy(530, 195, 4);
    shot(0);
    check("r42_hits", hit_cnt, 1);
    check("r42_expl", expl_cnt, 16);
    cycle();
    check("r42_idle", ShellActive, 0);
    // Fast rightward shell leaves the right edge.
    set_tank(630, 200, 4, 1, 3, 0);
    set_enemy(100, 50, 4);
    shot(0);
    check("r43_active_frames", act_cnt, 3);
    check("r43_nohit", hit_cnt, 0);
    // Down-aim clamps to +15 and reaches the ground; held shoot cannot relaunch.
    set_tank(300, 300, 4, 2, 0, -40);
    shot(1);
    check("r44_nohit", hit_cnt, 0);
    cycle();
    check("r44_idle", ShellActive, 0);
    // Asynchronous reset mid-flight, then a normal relaunch.
    set_tank(200, 300, 6, 1, 0, 20);
    shoot = 1;
    cycle();
    shoot = 0;
    cycle(); cycle(); cycle();
    #2;
    do_reset();
    shot(0);
    // Reset in the middle of an explosion.
    set_tank(550, 200, 4, 0, 1, 0);
    set_enemy(530, 195, 4);
    shoot = 1;
    cycle();
    shoot = 0;
    for (int i = 0; i < 12; i++) cycle();
    check("mid_expl", Exploding, 1);
    do_reset();
    cycle();
    for (int i = 0; i < 40; i++) begin
      int tx, ex;
      tx = $urandom_range(20, 620);
      set_tank(tx, $urandom_range(100, 470), $urandom_range(2, 20), $urandom_range(0, 3),
               $urandom_range(0, 3), int'($urandom_range(0, 80)) - 40);
      if ($urandom_range(0, 1) == 1) begin
        ex = tx + (Direction == 0 ? -1 : 1) * int'($urandom_range(5, 60));
        set_enemy(ex < 0 ? 0 : ex, int'(TankY) - int'($urandom_range(0, 30)), $urandom_range(2, 20));
      end else
        set_enemy($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 30));
      shot($urandom_range(0, 1) == 1);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
